dot_frame_buffer: RTL and testbench

Double-buffered 8x8 frame store that feeds the dot-matrix row scanner. It sits directly upstream of the scanner. A host writes rows into a back buffer and requests a commit. The commit copies the back buffer into the display buffer only at a frame boundary, so the matrix never shows a half-updated image. The read port returns one 8-bit column pattern per requested row, with optional circular horizontal scrolling.

---
 rtl/dot_frame_buffer.sv | 94 +++++++++
 tb/tb_dot_frame_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_frame_buffer.sv
// Double-buffered 8x8 dot-matrix frame store with frame-boundary commit
// and circular horizontal auto-scroll on the read path.
module dot_frame_buffer #(
    parameter int unsigned SCROLL_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       commit_pending,
    input  logic       rd_en,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       scroll_en,
    input  logic       scroll_dir,
    output logic [2:0] offset
);

    localparam logic [7:0] LAST_FRAME = 8'(SCROLL_FRAMES - 1);

    logic [7:0] back      [8];
    logic [7:0] front     [8];
    logic [7:0] back_next [8];
    logic [7:0] frame_cnt;
    logic       fb;

    function automatic logic [7:0] rot(input logic [7:0] v, input logic [2:0] n,
                                       input logic dir);
        logic [15:0] d;
        if (!dir) begin
            d = {v, v} << n;
            rot = d[15:8];
        end else begin
            d = {v, v} >> n;
            rot = d[7:0];
        end
    endfunction

    assign fb = rd_en && (rd_row == 3'd7);

    // Same-cycle write is forwarded into the commit copy
    always_comb begin
        back_next = back;
        if (wr_en) back_next[wr_row] = wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
            commit_pending <= 1'b0;
        end else begin
            back <= back_next;
            if (fb && commit_pending) begin
                front          <= back_next;
                commit_pending <= commit;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rot(front[rd_row], offset, scroll_dir);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (!scroll_en) begin
            frame_cnt <= '0;
        end else if (fb) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= '0;
                offset    <= scroll_dir ? offset - 3'd1 : offset + 3'd1;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dot_frame_buffer.sv
// Randomized self-checking bench for dot_frame_buffer against a
// behavioural frame-store model.
module tb_dot_frame_buffer;

    localparam int SF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = '0;
    logic [7:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic       rd_en = 1'b0;
    logic [2:0] rd_row = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       scroll_en = 1'b0;
    logic       scroll_dir = 1'b0;
    logic [2:0] offset;

    int checks = 0;
    int errors = 0;

    int m_back  [8];
    int m_front [8];
    int m_pend, m_off, m_cnt, m_rd, m_valid;

    dot_frame_buffer #(.SCROLL_FRAMES(SF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .commit(commit), .commit_pending(commit_pending), .rd_en(rd_en),
        .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid),
        .scroll_en(scroll_en), .scroll_dir(scroll_dir), .offset(offset)
    );

    always #5 clk = ~clk;

    // Bit-by-bit circular move: left sends bit i to (i+n)%8, right to (i-n)%8
    function automatic int model_rot(int v, int n, int dir);
        int r = 0;
        for (int i = 0; i < 8; i++)
            if ((v >> i) & 1)
                r |= 1 << (dir ? (i - n + 8) % 8 : (i + n) % 8);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_back[i] = 0; m_front[i] = 0; end
        m_pend = 0; m_off = 0; m_cnt = 0; m_rd = 0; m_valid = 0;
    endtask

    // Advance model by one clock using current inputs, then clock the DUT
    task automatic tick();
        int nb [8];
        bit fb;
        if (!rst) begin
            model_reset();
        end else begin
            fb = rd_en && rd_row == 7;
            if (rd_en) m_rd = model_rot(m_front[rd_row], m_off, scroll_dir);
            m_valid = rd_en;
            nb = m_back;
            if (wr_en) nb[wr_row] = wr_data;
            if (fb && m_pend) begin
                m_front = nb;
                m_pend = commit;
            end else if (commit) m_pend = 1;
            m_back = nb;
            if (!scroll_en) m_cnt = 0;
            else if (fb) begin
                if (m_cnt == SF - 1) begin
                    m_cnt = 0;
                    m_off = scroll_dir ? (m_off + 7) % 8 : (m_off + 1) % 8;
                end else m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; commit = 0; rd_en = 0;
    endtask

    task automatic read(int row);
        idle(); rd_en = 1; rd_row = 3'(row); tick(); rd_en = 0;
    endtask

    task automatic test_reset();
        wr_en = 1; wr_row = 3'($urandom); wr_data = 8'($urandom); commit = 1;
        rd_en = 1; rd_row = 3'($urandom); scroll_en = 1; scroll_dir = 1'($urandom);
        rst = 0;
        model_reset();
        tick(); tick();
        checks++;
        if ({rd_data, rd_valid, commit_pending, offset} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h valid=%b pend=%b off=%0d, required all 0",
                     rd_data, rd_valid, commit_pending, offset);
        end
        idle(); scroll_en = 0; scroll_dir = 0;
        rst = 1;
        for (int r = 0; r < 8; r++) begin
            read(r);
            checks++;
            if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL reset_row%0d: data=%h valid=%b, required 00/1", r, rd_data, rd_valid);
            end
        end
    endtask

    task automatic test_commit_gating();
        for (int r = 0; r < 8; r++) begin
            idle(); wr_en = 1; wr_row = 3'(r); wr_data = 8'((r + 1) * 17); tick();
        end
        idle(); commit = 1; tick(); idle();
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++; $display("FAIL gate_pending_rise: got %b, required 1", commit_pending);
        end
        for (int r = 0; r < 8; r++) begin
            read(r);
            checks++;
            if (rd_data !== 8'h00) begin
                errors++; $display("FAIL gate_old_row%0d: got %h, required 00", r, rd_data);
            end
        end
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++; $display("FAIL gate_pending_fall: got %b, required 0", commit_pending);
        end
        read(0);
        checks++;
        if (rd_data !== 8'h11) begin
            errors++; $display("FAIL gate_new_row0: got %h, required 11", rd_data);
        end
    endtask

    task automatic test_commit_edges();
        idle(); commit = 1; tick();
        idle(); rd_en = 1; rd_row = 7; wr_en = 1; wr_row = 3; wr_data = 8'hAA; commit = 1;
        tick(); idle();
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++; $display("FAIL edge_pending_kept: got %b, required 1", commit_pending);
        end
        read(3);
        checks++;
        if (rd_data !== 8'hAA) begin
            errors++; $display("FAIL edge_forward_row3: got %h, required AA", rd_data);
        end
        read(7);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++; $display("FAIL edge_pending_clear: got %b, required 0", commit_pending);
        end
        idle(); wr_en = 1; wr_row = 5; wr_data = 8'h5C; tick();
        idle(); rd_en = 1; rd_row = 7; commit = 1; tick(); idle();
        read(5);
        checks++;
        if (rd_data !== 8'h66 || commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL edge_no_early_copy: data=%h pend=%b, required 66/1", rd_data, commit_pending);
        end
        read(7); read(5);
        checks++;
        if (rd_data !== 8'h5C) begin
            errors++; $display("FAIL edge_late_copy: got %h, required 5C", rd_data);
        end
    endtask

    task automatic load_row0(logic [7:0] v);
        idle(); wr_en = 1; wr_row = 0; wr_data = v; commit = 1; tick();
        read(7);
    endtask

    task automatic test_scroll_left();
        load_row0(8'h81);
        scroll_en = 1; scroll_dir = 0;
        read(7); read(7);
        read(0);
        checks++;
        if (offset !== 3'd1 || rd_data !== 8'h03) begin
            errors++; $display("FAIL scroll_left_step: off=%0d data=%h, required 1/03", offset, rd_data);
        end
        for (int f = 2; f < 16; f++) read(7);
        read(0);
        checks++;
        if (offset !== 3'd0 || rd_data !== 8'h81) begin
            errors++; $display("FAIL scroll_left_wrap: off=%0d data=%h, required 0/81", offset, rd_data);
        end
        scroll_en = 0;
    endtask

    task automatic test_scroll_right_hold();
        load_row0(8'h01);
        scroll_en = 1; scroll_dir = 1;
        read(7); read(7);
        read(0);
        checks++;
        if (offset !== 3'd7 || rd_data !== 8'h02) begin
            errors++; $display("FAIL scroll_right_step: off=%0d data=%h, required 7/02", offset, rd_data);
        end
        read(7);
        scroll_en = 0; idle(); tick(); tick();
        scroll_en = 1;
        read(7);
        checks++;
        if (offset !== 3'd7) begin
            errors++; $display("FAIL scroll_hold_cnt_zero: off=%0d, required 7", offset);
        end
        read(7);
        checks++;
        if (offset !== 3'd6) begin
            errors++; $display("FAIL scroll_right_again: off=%0d, required 6", offset);
        end
        scroll_en = 0;
    endtask

    task automatic test_stall();
        logic [7:0] held;
        read(0);
        held = rd_data;
        idle();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== held || rd_data !== 8'(m_rd)) begin
                errors++; $display("FAIL stall_c%0d: valid=%b data=%h, required 0/%h", c, rd_valid, rd_data, held);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en = 1'($urandom); wr_row = 3'($urandom); wr_data = 8'($urandom);
            commit = ($urandom_range(0, 5) == 0);
            rd_en = ($urandom_range(0, 3) != 0);
            rd_row = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom);
            scroll_en = ($urandom_range(0, 9) != 0);
            scroll_dir = (c >= 200);
            tick();
            checks++;
            if ({rd_data, rd_valid, commit_pending, offset} !==
                {8'(m_rd), 1'(m_valid), 1'(m_pend), 3'(m_off)}) begin
                errors++;
                $display("FAIL random_c%0d: data=%h valid=%b pend=%b off=%0d, required %h/%0d/%0d/%0d",
                         c, rd_data, rd_valid, commit_pending, offset, m_rd, m_valid, m_pend, m_off);
            end
        end
        idle(); scroll_en = 0;
    endtask

    task automatic test_midreset();
        idle(); wr_en = 1; wr_row = 2; wr_data = 8'hF0; commit = 1; tick(); idle();
        read(4);
        #2 rst = 0;
        #1;
        model_reset();
        checks++;
        if ({rd_data, rd_valid, commit_pending, offset} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_async: data=%h valid=%b pend=%b off=%0d, required all 0",
                     rd_data, rd_valid, commit_pending, offset);
        end
        @(negedge clk);
        rst = 1;
        read(7);
        read(2);
        checks++;
        if (rd_data !== 8'h00 || commit_pending !== 1'b0) begin
            errors++; $display("FAIL midreset_lost: data=%h pend=%b, required 00/0", rd_data, commit_pending);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_commit_gating();
        test_commit_edges();
        test_scroll_left();
        test_scroll_right_hold();
        test_stall();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
